// File: rtl/cmpl_arb.sv
// cmpl_arb -- completion arbiter feeding the ROB completion port.
//
// Merges completions from M execution units into one registered
// cmpl_vld/cmpl_id/cmpl_data stream. The ROB cannot stall, so each source
// owns a small in-order FIFO. A round-robin arbiter drains the FIFO heads at
// one completion per cycle.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   src_vld/id/data     per-source completion offer (slice i of each bus)
//   src_rdy             per-source accept: FIFO not full and no clear
//   clear               synchronous flush: empties FIFOs, resets pointer
//   cmpl_vld/id/data    registered completion toward the ROB
//   busy_r              registered: any FIFO non-empty or cmpl_vld set
//
// Optional feature macro: CMPL_ARB_BYPASS_EN
//   When defined and every FIFO is empty, incoming offers are arbitrated
//   directly, giving a latency of 1. The winning offer skips its FIFO.
module cmpl_arb #(
    parameter int M      = 4,
    parameter int N      = 16,
    parameter int CMPL_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [M-1:0]              src_vld,
    input  logic [M*$clog2(N)-1:0]    src_id,
    input  logic [M*CMPL_W-1:0]       src_data,
    output logic [M-1:0]              src_rdy,
    input  logic                      clear,
    output logic                      cmpl_vld,
    output logic [$clog2(N)-1:0]      cmpl_id,
    output logic [CMPL_W-1:0]         cmpl_data,
    output logic                      busy_r
);

    localparam int IW   = $clog2(N);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int MW   = $clog2(M);
    localparam int EW   = IW + CMPL_W;

    logic [M-1:0]    full;
    logic [M-1:0]    empty;
    logic [M-1:0]    push;
    logic [M-1:0]    pop;
    logic [M-1:0]    byp_win;
    logic [M-1:0]    cnt_nz_d;
    logic [EW-1:0]   head [M];

    logic [MW-1:0]   p_q, p_d;
    logic            cmpl_vld_q, cmpl_vld_d;
    logic [IW-1:0]   cmpl_id_q, cmpl_id_d;
    logic [CMPL_W-1:0] cmpl_data_q, cmpl_data_d;
    logic            busy_q, busy_d;

    logic [M-1:0]    cand;
    logic            use_byp;
    logic            grant_vld;
    logic [MW-1:0]   grant_idx;
    logic [IW-1:0]   sel_id;
    logic [CMPL_W-1:0] sel_data;

    // src_rdy depends only on registered occupancy and clear, never on src_vld.
    assign src_rdy = ~full & {M{~clear}};
    // A source that wins the bypass is delivered directly and must not also be queued.
    assign push    = src_vld & src_rdy & ~byp_win;

    // ---------------- per-source FIFOs ----------------
    for (genvar gi = 0; gi < M; gi++) begin : g_fifo
        logic [PW-1:0]   wptr_q, wptr_d;
        logic [PW-1:0]   rptr_q, rptr_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic [EW-1:0]   mem_q [DEPTH];

        assign full[gi]     = (cnt_q == CNTW'(DEPTH));
        assign empty[gi]    = (cnt_q == '0);
        assign head[gi]     = mem_q[rptr_q];
        assign cnt_nz_d[gi] = (cnt_d != '0);

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (clear) begin
                wptr_d = '0;
                rptr_d = '0;
                cnt_d  = '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap naturally.
                if (push[gi]) wptr_d = wptr_q + PW'(1);
                if (pop[gi])  rptr_d = rptr_q + PW'(1);
                case ({push[gi], pop[gi]})
                    2'b10:   cnt_d = cnt_q + CNTW'(1);
                    2'b01:   cnt_d = cnt_q - CNTW'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Storage has no reset; occupancy alone defines which entries are valid.
        always_ff @(posedge clk) begin
            if (push[gi]) mem_q[wptr_q] <= {src_id[gi*IW +: IW], src_data[gi*CMPL_W +: CMPL_W]};
        end
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        int idx;
        cand      = ~empty;
        use_byp   = 1'b0;
`ifdef CMPL_ARB_BYPASS_EN
        if ((&empty) && !clear) begin
            use_byp = 1'b1;
            cand    = src_vld;
        end
`endif
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < M; k++) begin
            idx = int'(p_q) + k;
            if (idx >= M) idx = idx - M;
            if (!grant_vld && cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = MW'(idx);
            end
        end
        if (clear) grant_vld = 1'b0;

        pop     = '0;
        byp_win = '0;
        if (grant_vld) begin
            if (use_byp) byp_win[grant_idx] = 1'b1;
            else         pop[grant_idx]     = 1'b1;
        end

        if (use_byp) begin
            sel_id   = src_id[grant_idx*IW +: IW];
            sel_data = src_data[grant_idx*CMPL_W +: CMPL_W];
        end else begin
            sel_id   = head[grant_idx][EW-1 -: IW];
            sel_data = head[grant_idx][CMPL_W-1:0];
        end

        if (clear)          p_d = '0;
        else if (grant_vld) p_d = (grant_idx == MW'(M - 1)) ? '0 : grant_idx + MW'(1);
        else                p_d = p_q;

        cmpl_vld_d  = grant_vld;
        cmpl_id_d   = grant_vld ? sel_id   : cmpl_id_q;
        cmpl_data_d = grant_vld ? sel_data : cmpl_data_q;
        busy_d      = (|cnt_nz_d) | cmpl_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            cmpl_vld_q  <= 1'b0;
            cmpl_id_q   <= '0;
            cmpl_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            p_q         <= p_d;
            cmpl_vld_q  <= cmpl_vld_d;
            cmpl_id_q   <= cmpl_id_d;
            cmpl_data_q <= cmpl_data_d;
            busy_q      <= busy_d;
        end
    end

    assign cmpl_vld  = cmpl_vld_q;
    assign cmpl_id   = cmpl_id_q;
    assign cmpl_data = cmpl_data_q;
    assign busy_r    = busy_q;

endmodule

// File: tb/tb_cmpl_arb.sv
// tb_cmpl_arb -- scoreboard bench for cmpl_arb.
// A cycle model queues accepted offers per source and pushes each expected
// completion onto a scoreboard queue at the edge where it is granted. The
// monitor pops and compares each entry when the DUT raises cmpl_vld.
module tb_cmpl_arb;
    localparam int M      = 4;
    localparam int N      = 16;
    localparam int CMPL_W = 32;
    localparam int DEPTH  = 2;
    localparam int IW     = 4;
`ifdef CMPL_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 0 : 1;   // edges between accept edge and the output edge

    typedef logic [IW+CMPL_W-1:0] ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [M-1:0]      src_vld;
    logic [M*IW-1:0]   src_id;
    logic [M*CMPL_W-1:0] src_data;
    logic [M-1:0]      src_rdy;
    logic              clear;
    logic              cmpl_vld;
    logic [IW-1:0]     cmpl_id;
    logic [CMPL_W-1:0] cmpl_data;
    logic              busy_r;

    cmpl_arb #(.M(M), .N(N), .CMPL_W(CMPL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_id(src_id),
        .src_data(src_data), .src_rdy(src_rdy), .clear(clear),
        .cmpl_vld(cmpl_vld), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data),
        .busy_r(busy_r)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ent_t mq [M][$];
    ent_t exp_q [$];
    int   p_m = 0;
    bit   exp_vld = 0;
    bit   busy_m = 0;
    logic [M-1:0] acc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle model plus output monitor.
    always @(posedge clk) begin
        int   g;
        bit   all_empty;
        bit   byp;
        logic [M-1:0] cand;
        logic [M-1:0] exp_rdy;
        ent_t e;
        cyc++;
        acc     = '0;
        exp_vld = 1'b0;
        if (!rst_n || clear) begin
            for (int i = 0; i < M; i++) mq[i].delete();
            if (!rst_n) exp_q.delete();
            p_m = 0;
        end else begin
            all_empty = 1'b1;
            for (int i = 0; i < M; i++) begin
                cand[i] = (mq[i].size() != 0);
                acc[i]  = src_vld[i] && (mq[i].size() < DEPTH);
                if (mq[i].size() != 0) all_empty = 1'b0;
            end
            byp = BYP && all_empty;
            if (byp) cand = src_vld;
            g = -1;
            for (int k = 0; k < M; k++) begin
                int idx;
                idx = (p_m + k) % M;
                if (g < 0 && cand[idx]) g = idx;
            end
            if (g >= 0) begin
                exp_vld = 1'b1;
                if (byp) exp_q.push_back({src_id[g*IW +: IW], src_data[g*CMPL_W +: CMPL_W]});
                else     exp_q.push_back(mq[g].pop_front());
                p_m = (g + 1) % M;
            end
            for (int i = 0; i < M; i++)
                if (acc[i] && !(byp && g == i))
                    mq[i].push_back({src_id[i*IW +: IW], src_data[i*CMPL_W +: CMPL_W]});
        end
        busy_m = exp_vld;
        for (int i = 0; i < M; i++) if (mq[i].size() != 0) busy_m = 1'b1;

        #1;
        chk("cmpl_vld", cmpl_vld, exp_vld);
        chk("busy_r", busy_r, busy_m);
        if (rst_n) begin
            for (int i = 0; i < M; i++) exp_rdy[i] = (mq[i].size() < DEPTH) && !clear;
            chk("src_rdy", src_rdy, exp_rdy);
        end
        if (cmpl_vld) begin
            $display("cmpl id=%0d data=%08h", cmpl_id, cmpl_data);
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cmpl_id", cmpl_id, e[IW+CMPL_W-1 -: IW]);
                chk("cmpl_data", cmpl_data, e[CMPL_W-1:0]);
            end
        end
    end

    task automatic set_src(input int i, input logic [IW-1:0] id, input logic [CMPL_W-1:0] d);
        src_id[i*IW +: IW]         = id;
        src_data[i*CMPL_W +: CMPL_W] = d;
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (cmpl_vld) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Single uncontended completion: checks latency, payload and return to idle.
    task automatic lat_test(input int s, input logic [IW-1:0] id, input logic [CMPL_W-1:0] d);
        bit ok;
        int c0;
        @(negedge clk);
        src_vld    = '0;
        src_vld[s] = 1'b1;
        set_src(s, id, d);
        @(negedge clk);
        src_vld = '0;
        c0 = cyc;
        wait_vld(ok);
        chk("lat_seen", ok, 1);
        chk("lat_cycles", cyc - c0, LAT);
        chk("lat_id", cmpl_id, id);
        chk("lat_data", cmpl_data, d);
        @(negedge clk);
        chk("lat_vld_drop", cmpl_vld, 0);
        chk("lat_busy_idle", busy_r, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit saw;
        logic [IW-1:0] id0, id1;
        rst_n = 1'b0; clear = 1'b0; src_vld = '0; src_id = '0; src_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_vld", cmpl_vld, 0);
        chk("rst_id", cmpl_id, 0);
        chk("rst_data", cmpl_data, 0);
        chk("rst_busy", busy_r, 0);
        rst_n = 1'b1;
        #1 chk("rst_rdy", src_rdy, 4'hF);

        // Single source 2.
        lat_test(2, 4'd5, 32'hA5A5A5A5);

        // All four sources at once after a clear (pointer back to 0).
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        src_vld = 4'hF;
        for (int i = 0; i < M; i++) set_src(i, IW'(i + 1), 32'h1000_0000 * (i + 1) + 32'h77);
        @(negedge clk); src_vld = '0;
        wait_vld(ok);
        chk("rr_seen", ok, 1);
        for (int j = 0; j < M; j++) begin
            chk("rr_vld", cmpl_vld, 1);
            chk("rr_id", cmpl_id, j + 1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Sources 0 and 1 both stream; source 1 must see backpressure.
        id0 = '0; id1 = '0; saw = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            src_vld = 4'b0011;
            set_src(0, id0, {8'h10, 20'h5A5A5, id0});
            set_src(1, id1, {8'h20, 20'h3C3C3, id1});
            @(negedge clk);
            if (acc[0]) id0++;
            if (acc[1]) id1++;
            if (!src_rdy[1]) saw = 1'b1;
        end
        src_vld = '0;
        chk("rdy1_backpressure", saw, 1);
        repeat (8) @(negedge clk);

        // Fill sources 0 and 3, then clear.
        for (int c = 0; c < 3; c++) begin
            src_vld = 4'b1001;
            set_src(0, IW'(c), 32'hD000_0000 + c);
            set_src(3, IW'(c + 8), 32'hE000_0000 + c);
            @(negedge clk);
        end
        src_vld = '0; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1;
        chk("clr_vld", cmpl_vld, 0);
        chk("clr_busy", busy_r, 0);
        chk("clr_rdy", src_rdy, 4'hF);
        lat_test(3, 4'd9, 32'h3333_0009);

        // Asynchronous reset with entries pending.
        @(negedge clk);
        src_vld = 4'b0111;
        for (int i = 0; i < 3; i++) set_src(i, IW'(10 + i), 32'hBEEF_0000 + i);
        @(negedge clk); src_vld = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", cmpl_vld, 0);
        chk("async_rst_busy", busy_r, 0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        lat_test(1, 4'd6, 32'h1234_5678);

        // Back-to-back stream of ids 0..7 from source 0.
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    src_vld = 4'b0001;
                    set_src(0, IW'(k), 32'hC0DE_0000 + k);
                    chk("stream_rdy", src_rdy[0], 1);
                    @(negedge clk);
                end
                src_vld = '0;
            end
            begin
                bit ok2;
                wait_vld(ok2);
                chk("stream_seen", ok2, 1);
                for (int j = 0; j < 8; j++) begin
                    chk("stream_vld", cmpl_vld, 1);
                    chk("stream_id", cmpl_id, j);
                    @(negedge clk);
                end
            end
        join

        repeat (6) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("final_busy", busy_r, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
